// File: rtl/lstm_pkg.sv
// Shared LSTM definitions used by the element-wise compute controller.
// Holds the pipeline depth constants, the controller state encoding and
// the layout of one buffered h_t entry.
package lstm_pkg;

  localparam int unsigned LSTM_HIDDEN_SIZE    = 16;
  localparam int unsigned LSTM_IDX_BITS       = 4;
  localparam int unsigned LSTM_INPUT_BITS     = 16;
  localparam int unsigned NUM_LSTM_ACT_STAGE  = 5;
  localparam int unsigned NUM_LSTM_MULT_STAGE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } LSTM_CTRL_STATE;

  typedef struct packed {
    logic [LSTM_INPUT_BITS-1:0] data;
    logic [LSTM_IDX_BITS-1:0]   idx;
  } LSTM_H_ENTRY;

endpackage

// File: rtl/lstm_out_fifo.sv
// Synchronous FIFO buffering h_t results for the downstream consumer.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   push/push_data - write one entry (dropped if full; flagged by assertion)
//   pop            - remove the head entry when one is present
//   head_valid     - FIFO holds at least one entry
//   head_data      - head entry, reads 0 while empty
//   count          - number of stored entries
module lstm_out_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                full;
  logic                do_push;
  logic                do_pop;

  always_comb begin
    full       = (count_q == CNT_BITS'(DEPTH));
    head_valid = (count_q != '0);
    do_push    = push && !full;
    do_pop     = pop && head_valid;
    head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    count      = count_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Admission credits should make a push into a full buffer impossible.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/lstm_compute_ctrl.sv
// Sequencer and h_t output buffer for the LSTM element-wise datapath.
// Admits HIDDEN_SIZE gate packets per timestep, tags each launched element
// with its index as it travels the fixed-latency datapath, times the CRAM
// read of c_(t-1) and write of c_t, and captures h_t into a FIFO.
// Ports:
//   clock, reset               - clock and synchronous active-high reset
//   start                      - begin a timestep (honoured in IDLE only)
//   busy, done                 - RUN/DRAIN indicator, last-capture pulse
//   gate_valid/gate_ready      - CMVU packet handshake
//   dp_launch                  - packet enters the datapath this cycle
//   cram_rd_en/cram_rd_addr    - read c_(t-1) for the tagged element
//   cram_wr_en/cram_wr_addr    - write c_t for the tagged element
//   dp_h_data                  - datapath h_t output
//   out_valid/out_ready        - output handshake
//   out_data/out_idx           - buffered h_t value and its element index
module lstm_compute_ctrl
  import lstm_pkg::*;
#(
  parameter int unsigned HIDDEN_SIZE = LSTM_HIDDEN_SIZE,
  parameter int unsigned IDX_BITS    = LSTM_IDX_BITS,
  parameter int unsigned DATA_BITS   = LSTM_INPUT_BITS,
  parameter int unsigned ACT_LAT     = NUM_LSTM_ACT_STAGE,
  parameter int unsigned MULT_LAT    = NUM_LSTM_MULT_STAGE,
  parameter int unsigned CRAM_RD_LAT = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 gate_valid,
  output logic                 gate_ready,
  output logic                 dp_launch,
  output logic                 cram_rd_en,
  output logic [IDX_BITS-1:0]  cram_rd_addr,
  output logic                 cram_wr_en,
  output logic [IDX_BITS-1:0]  cram_wr_addr,
  input  logic [DATA_BITS-1:0] dp_h_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [IDX_BITS-1:0]  out_idx
);

  localparam int unsigned L_C      = ACT_LAT + MULT_LAT + 1;
  localparam int unsigned L_H      = L_C + ACT_LAT + MULT_LAT;
  localparam int unsigned RD_OFF   = ACT_LAT - CRAM_RD_LAT;
  localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(HIDDEN_SIZE - 1);

  typedef struct packed {
    logic                valid;
    logic [IDX_BITS-1:0] idx;
  } tag_t;

  LSTM_CTRL_STATE       state_q, state_d;
  logic [IDX_BITS-1:0]  issue_idx_q, issue_idx_d;
  logic [CNT_BITS-1:0]  inflight_q, inflight_d;
  tag_t                 tag_q [L_H];
  tag_t                 tag_d [L_H];

  logic [CNT_BITS-1:0]  fifo_count;
  logic [CNT_BITS:0]    credit_sum;
  logic                 credit_ok;
  logic                 capture;
  logic                 last_capture;
  LSTM_H_ENTRY          push_entry;
  LSTM_H_ENTRY          head_entry;

  // Stage j of the tag pipe holds the element launched j+1 cycles ago.
  always_comb begin
    tag_d[0].valid = dp_launch;
    tag_d[0].idx   = issue_idx_q;
    for (int unsigned i = 1; i < L_H; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    capture      = tag_q[L_H-1].valid;
    last_capture = capture && (inflight_q == CNT_BITS'(1));
    credit_sum   = {1'b0, inflight_q} + {1'b0, fifo_count};
    credit_ok    = (credit_sum < (CNT_BITS+1)'(FIFO_DEPTH));
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({dp_launch, capture})
      2'b10:   inflight_d = inflight_q + CNT_BITS'(1);
      2'b01:   inflight_d = inflight_q - CNT_BITS'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State register and all controller flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      inflight_q  <= '0;
      for (int unsigned i = 0; i < L_H; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          issue_idx_d = '0;
        end
      end
      RUN: begin
        if (dp_launch) begin
          issue_idx_d = issue_idx_q + IDX_BITS'(1);
          if (issue_idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_capture) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy         = (state_q != IDLE);
    gate_ready   = (state_q == RUN) && credit_ok;
    dp_launch    = gate_valid && gate_ready;
    done         = (state_q == DRAIN) && last_capture;
    cram_rd_en   = tag_q[RD_OFF-1].valid;
    cram_rd_addr = cram_rd_en ? tag_q[RD_OFF-1].idx : '0;
    cram_wr_en   = tag_q[L_C-1].valid;
    cram_wr_addr = cram_wr_en ? tag_q[L_C-1].idx : '0;
  end

  always_comb begin
    push_entry.data = LSTM_INPUT_BITS'(dp_h_data);
    push_entry.idx  = LSTM_IDX_BITS'(tag_q[L_H-1].idx);
    out_data        = DATA_BITS'(head_entry.data);
    out_idx         = IDX_BITS'(head_entry.idx);
  end

  lstm_out_fifo #(
    .WIDTH ($bits(LSTM_H_ENTRY)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (capture),
    .push_data  (push_entry),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

endmodule
